// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: control sequencer for the pixel-load -> conv -> readout pipeline of the 8x8 CNN accelerator.
//   clk, reset     : clock, synchronous active-high reset
//   start, abort   : begin a frame (IDLE only) / return to IDLE from anywhere
//   pix_*, buf_*   : pixel handshake and image-buffer write strobe/address
//   conv_*         : per-window launch pulse, window index, completion
//   res_*          : result readout handshake and read index
//   busy, frame_done, err : status, end-of-frame pulse, sticky timeout flag
module cnn_frame_sequencer #(
  parameter int NUM_PIXELS    = 64,
  parameter int NUM_POSITIONS = 36,
  parameter int TIMEOUT       = 64,
  parameter int IDXW          = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            buf_we,
  output logic [IDXW-1:0] buf_addr,
  output logic            conv_start,
  output logic [IDXW-1:0] conv_pos,
  input  logic            conv_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDXW-1:0] res_idx,
  output logic            busy,
  output logic            frame_done,
  output logic            err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST_PIX = IDXW'(NUM_PIXELS - 1);
  localparam logic [IDXW-1:0] LAST_POS = IDXW'(NUM_POSITIONS - 1);
  localparam logic [TW-1:0]   LAST_TMO = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, READOUT} state_t;
  state_t state_q, state_d;
  logic [IDXW-1:0] addr_q, addr_d, pos_q, pos_d, idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic conv_start_q, conv_start_d, frame_done_q, frame_done_d, err_q, err_d;
  logic done, hs;
  assign pix_ready  = state_q == LOAD;
  assign buf_we     = pix_valid & pix_ready;
  assign res_valid  = state_q == READOUT;
  assign hs         = res_valid & res_ready;
  // a completion coinciding with its own launch pulse is not a real completion
  assign done       = conv_done & ~conv_start_q;
  assign buf_addr   = addr_q;
  assign conv_pos   = pos_q;
  assign res_idx    = idx_q;
  assign conv_start = conv_start_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pos_d        = pos_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    conv_start_d = 1'b0;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
      pos_d   = '0;
      idx_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          pos_d   = '0;
          idx_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
        LOAD: if (buf_we) begin
          addr_d = addr_q == LAST_PIX ? '0 : addr_q + 1'b1;
          if (addr_q == LAST_PIX) begin
            state_d      = COMPUTE;
            conv_start_d = 1'b1;
            tmo_d        = '0;
          end
        end
        COMPUTE: begin
          // completion takes precedence over a timeout expiring in the same cycle
          if (done) begin
            tmo_d        = '0;
            pos_d        = pos_q == LAST_POS ? '0 : pos_q + 1'b1;
            conv_start_d = pos_q != LAST_POS;
            state_d      = pos_q == LAST_POS ? READOUT : COMPUTE;
          end else if (tmo_q == LAST_TMO) begin
            state_d = IDLE;
            err_d   = 1'b1;
            pos_d   = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        READOUT: if (hs) begin
          idx_d = idx_q == LAST_POS ? '0 : idx_q + 1'b1;
          if (idx_q == LAST_POS) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pos_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      conv_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pos_q        <= pos_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      conv_start_q <= conv_start_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: scoreboard bench with a cycle-accurate procedural frame model.
module tb_cnn_frame_sequencer;
  localparam int NP = 64, NQ = 36, TO = 64, W = 6;
  logic clk = 0, reset = 1, start = 0, abort = 0, pix_valid = 0, conv_done = 0, res_ready = 0;
  logic pix_ready, buf_we, conv_start, res_valid, busy, frame_done, err;
  logic [W-1:0] buf_addr, conv_pos, res_idx;
  cnn_frame_sequencer #(.NUM_PIXELS(NP), .NUM_POSITIONS(NQ), .TIMEOUT(TO), .IDXW(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .buf_we(buf_we), .buf_addr(buf_addr), .conv_start(conv_start),
    .conv_pos(conv_pos), .conv_done(conv_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .busy(busy), .frame_done(frame_done), .err(err));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {string k; int v; int c;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  task automatic push(input string k, input int v, input int c);
    ev_t e;
    e.k = k;
    e.v = v;
    e.c = c;
    q.push_back(e);
  endtask
  task automatic pop(input string k, input int v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got value %0d at cycle %0d, expected no event", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.v != v || e.c != cyc) begin
        errors++;
        $display("FAIL event got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d", k, v, cyc, e.k, e.v, e.c);
      end
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  logic err_p = 0;
  always @(negedge clk) begin
    if (buf_we) pop("W", int'(buf_addr));
    if (conv_start) pop("C", int'(conv_pos));
    if (res_valid && res_ready) pop("R", int'(res_idx));
    if (frame_done) pop("F", 0);
    if (err && !err_p) pop("E", 1);
    err_p = err;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] all_outs();
    return 32'({pix_ready, buf_we, buf_addr, conv_start, conv_pos, res_valid, res_idx, busy, frame_done, err});
  endfunction
  // bub: 0 back-to-back, 1 every other cycle, 2 random; stall: 0 none, 1 three cycles at idx 10, 2 random
  task automatic frame(input int bub, input int lat_fix, input int wh, input int ex, input int stall,
                       input int ab_load, input int ab_read, input int rst_pos);
    int k, cs, lat, j, sc;
    logic rr;
    start = 1;
    tick;
    start = 0;
    chk("start_busy_ready_err", 32'({busy, pix_ready, err}), 32'b110);
    k = 0;
    while (k < NP) begin
      pix_valid = bub == 0 ? 1'b1 : bub == 1 ? (cyc % 2 == 1) : 1'($urandom % 2);
      conv_done = 1'($urandom % 2);
      if (k == ab_load) begin
        chk("addr_before_abort", 32'(buf_addr), 32'(k));
        pix_valid = 0;
        abort = 1;
        tick;
        abort = 0;
        conv_done = 0;
        chk("abort_load_idle", 32'({busy, pix_ready}), 32'd0);
        return;
      end
      if (pix_valid) begin
        push("W", k, cyc);
        k++;
      end
      tick;
    end
    pix_valid = 0;
    conv_done = 0;
    chk("load_closed", 32'(pix_ready), 32'd0);
    for (int p = 0; p < NQ; p++) begin
      cs = cyc;
      push("C", p, cs);
      conv_done = ($urandom % 3 == 0);
      if (p == rst_pos) begin
        tick;
        conv_done = 0;
        reset = 1;
        tick;
        reset = 0;
        chk("reset_mid_compute", all_outs(), 32'd0);
        return;
      end
      lat = p == wh ? TO : p == ex ? TO - 1 : lat_fix > 0 ? lat_fix : $urandom_range(1, 8);
      for (int i = 1; i < lat; i++) begin
        tick;
        conv_done = 0;
        start = ($urandom % 4 == 0);
      end
      tick;
      start = 0;
      if (p == wh) begin
        conv_done = 0;
        push("E", 1, cyc);
        chk("timeout_err_idle", 32'({err, busy}), 32'b10);
        return;
      end
      conv_done = 1;
      tick;
      conv_done = 0;
    end
    j = 0;
    sc = 0;
    while (j < NQ) begin
      conv_done = 1'($urandom % 2);
      if (j == ab_read) begin
        chk("idx_before_abort", 32'(res_idx), 32'(j));
        res_ready = 0;
        abort = 1;
        tick;
        abort = 0;
        conv_done = 0;
        chk("abort_read_idle", 32'({busy, res_valid}), 32'd0);
        return;
      end
      rr = stall == 0 ? 1'b1 : stall == 1 ? !(j == 10 && sc < 3) : 1'($urandom % 2);
      if (stall == 1 && j == 10 && sc < 3) begin
        chk("idx_hold", 32'(res_idx), 32'd10);
        sc++;
      end
      res_ready = rr;
      if (rr) begin
        push("R", j, cyc);
        j++;
      end
      tick;
    end
    res_ready = 0;
    conv_done = 0;
    push("F", 0, cyc);
    chk("frame_done_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    reset = 1;
    tick;
    tick;
    reset = 0;
    chk("reset_outputs", all_outs(), 32'd0);
    frame(0, 5, -1, -1, 0, -1, -1, -1);
    tick;
    frame(1, 0, -1, -1, 1, -1, -1, -1);
    tick;
    frame(2, 0, 7, -1, 2, -1, -1, -1);
    tick;
    frame(0, 0, -1, 7, 0, -1, -1, -1);
    tick;
    frame(0, 0, -1, -1, 0, 20, -1, -1);
    tick;
    frame(2, 0, -1, -1, 2, -1, -1, -1);
    tick;
    frame(0, 3, -1, -1, 0, -1, 5, -1);
    tick;
    frame(1, 0, -1, -1, 0, -1, -1, -1);
    tick;
    start = 1;
    abort = 1;
    tick;
    start = 0;
    abort = 0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    frame(2, 0, -1, -1, 2, -1, -1, 12);
    tick;
    for (int r = 0; r < 3; r++) begin
      frame(2, 0, -1, -1, 2, -1, -1, -1);
      tick;
    end
    tick;
    tick;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Top-level controller for the pixel-load → conv → readout pipeline of the 8×8 CNN accelerator. It accepts a frame start and streams NUM_PIXELS pixels into the image buffer with a valid/ready handshake. It then issues one conv_start per output window and waits for the conv engine's per-window completion. Finally it steps a readout index through all results under a valid/ready handshake. It owns no datapath arithmetic; it only generates enables, addresses and window indices for the buffer, conv engine and result store.

## Interface
- NUM_PIXELS, 64, pixels per frame.
- NUM_POSITIONS, 36, conv output windows per frame.
- TIMEOUT, 64, maximum cycles from conv_start to conv_done.
- IDXW, 6, width of buf_addr / conv_pos / res_idx; must be ≥ clog2(max(NUM_PIXELS, NUM_POSITIONS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  return to IDLE from any state.
- pix_valid  in  1  pixel beat offered.
- pix_ready  out  1  sequencer accepts a pixel (high only in LOAD).
- buf_we  out  1  image-buffer write strobe; equals pix_valid & pix_ready (combinational).
- buf_addr  out  IDXW  write address = count of pixels already accepted this frame.
- conv_start  out  1  one-cycle pulse launching window conv_pos.
- conv_pos  out  IDXW  current window index.
- conv_done  in  1  conv engine finished current window.
- res_valid  out  1  result at res_idx is ready to be read (high only in READOUT).
- res_ready  in  1  consumer takes the result.
- res_idx  out  IDXW  result read address.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after the last result is taken.
- err  out  1  sticky timeout flag; cleared by the next accepted start or by reset.

## Operation
- State encoding (states): IDLE, LOAD, COMPUTE, READOUT.
- IDLE:
  - start → LOAD; clear all counters and err.
  - start outside IDLE is ignored.
- LOAD:
  - pix_ready = 1.
  - Each beat with pix_valid = 1 writes pixel_data at buf_addr, then buf_addr increments.
  - The beat accepted at buf_addr = NUM_PIXELS−1 moves to COMPUTE next cycle. Exactly NUM_PIXELS beats are accepted; pix_ready is low on the following cycle.
- COMPUTE:
  - conv_start (registered) is high on the first COMPUTE cycle with conv_pos = 0. The timeout counter is cleared.
  - Waiting for a window:
    - conv_done while conv_pos < NUM_POSITIONS−1: conv_pos increments and conv_start pulses on the next cycle for the new index.
    - conv_done with conv_pos = NUM_POSITIONS−1 → READOUT.
  - Timeout counter increments each cycle while waiting. Reaching TIMEOUT without conv_done sets err and moves to IDLE; no frame_done is pulsed.
  - conv_done in the same cycle as timeout expiry: conv_done wins and err is not set.
  - conv_done in the same cycle as conv_start is illegal and is ignored.
  - conv_done outside COMPUTE is ignored.
- READOUT:
  - res_valid = 1, res_idx starts at 0.
  - Each res_valid & res_ready increments res_idx.
  - The handshake at res_idx = NUM_POSITIONS−1 pulses frame_done next cycle and returns to IDLE.
  - res_idx is held while res_ready = 0.
- abort:
  - Highest priority after reset. Next state is IDLE; counters clear; no frame_done; err unchanged.
  - abort and start together in IDLE: stay IDLE.
- Counters never wrap within a frame; every terminal compare is against the parameter minus one.

## Timing
- Reset values: every output is 0 and state is IDLE.
- Frame start:
  - start sampled at cycle t.
  - busy = 1 and pix_ready = 1 at t+1.
- Load phase: with pix_valid held high, the last pixel is accepted at t+NUM_PIXELS and the first conv_start occurs at t+NUM_PIXELS+1.
- Per-window overhead: 1 cycle (conv_done → next conv_start).
- Readout: with res_ready held high, one result per cycle; frame_done occurs one cycle after the last handshake, coincident with busy = 0.
- Reset mid-frame: all outputs 0 on the next cycle. Partial frame state is discarded.

## Test plan
- Nominal frame:
  - Stimulus: start; 64 back-to-back pixels; conv_done 5 cycles after each conv_start; res_ready held high.
  - Required: exactly 64 buf_we with addresses 0..63; 36 conv_start pulses with conv_pos 0..35; res_idx 0..35; one frame_done; err = 0.
- Bubbled load and readout:
  - Stimulus: pix_valid toggling every other cycle; res_ready low for 3 cycles at res_idx = 10.
  - Required: addresses contiguous with no skips; res_idx held at 10 for those 3 cycles.
- Timeout:
  - Stimulus: withhold conv_done at conv_pos = 7.
  - Required: err = 1 and state IDLE exactly TIMEOUT cycles after that conv_start; no frame_done.
  - Follow-up: next start clears err.
  - Separate case: conv_done in the expiry cycle advances to conv_pos = 8 with err = 0.
- Abort:
  - Stimulus: abort during LOAD at buf_addr = 20, and again during READOUT at res_idx = 5.
  - Required: IDLE and busy = 0 next cycle; a new frame restarts at address 0.
- Ignored and simultaneous inputs:
  - start during COMPUTE: no effect.
  - conv_done in LOAD: no effect.
  - start + abort in IDLE: remains IDLE.
- Reset mid-COMPUTE at conv_pos = 12: all outputs 0 next cycle; the following frame completes normally.
